// File: rtl/ports_regbank_pkg.sv
// Shared types and constants for the Z80 I/O port register bank.
// Holds the write FSM state encoding and the classic port addresses and decode masks.
package ports_regbank_pkg;

  typedef enum logic [1:0] {
    PRB_IDLE    = 2'd0,
    PRB_WAIT_CK = 2'd1,
    PRB_DONE    = 2'd2
  } prb_state_e;

  localparam logic [15:0] PORT_7FFD = 16'h7FFD;
  localparam logic [15:0] PORT_DFFD = 16'hDFFD;
  localparam logic [15:0] PORT_1FFD = 16'h1FFD;

  localparam logic [15:0] MASK_7FFD = 16'h8002;
  localparam logic [15:0] MASK_DFFD = 16'hFFFF;
  localparam logic [15:0] MASK_1FFD = 16'hF002;

endpackage

// File: rtl/cpu_bus.sv
// Z80 CPU bus as seen by I/O peripherals on the 28 MHz clock domain.
interface cpu_bus;
  logic        ioreq;
  logic        rd;
  logic        wr;
  logic [15:0] a;
  logic [7:0]  d;

  modport slave (input ioreq, rd, wr, a, d);
endinterface

// File: rtl/ports_regbank_ch.sv
// One register channel: storage, lock gating of the commit, write strobe and readback data.
module ports_regbank_ch #(
  parameter int             DW        = 8,
  parameter logic [DW-1:0]  RESET_VAL = '0,
  parameter logic           LOCKABLE  = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cs_i,
  input  logic          commit_i,
  input  logic          locked_i,
  input  logic          unlock_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o,
  output logic          wr_stb_o,
  output logic [7:0]    rdata_o
);

  logic [DW-1:0] q_q, q_d;
  logic          wr_stb_q;
  logic          blocked_s;
  logic          wr_en_s;

  assign blocked_s = LOCKABLE & locked_i & ~unlock_i;
  assign wr_en_s   = commit_i & cs_i & ~blocked_s;

  always_comb begin
    q_d = q_q;
    if (wr_en_s) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q      <= RESET_VAL;
      wr_stb_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      wr_stb_q <= wr_en_s;
    end
  end

  always_comb begin
    rdata_o         = 8'h00;
    rdata_o[DW-1:0] = q_q;
  end

  assign q_o      = q_q;
  assign wr_stb_o = wr_stb_q;

endmodule

// File: rtl/ports_regbank.sv
// Parametrised bank of write/readback I/O registers on the Z80 bus.
// A shared write FSM guarantees one commit per CPU write cycle, optionally aligned to clkcpu_ck.
module ports_regbank
  import ports_regbank_pkg::*;
#(
  parameter int                   NPORTS    = 3,
  parameter int                   DW        = 8,
  parameter logic [NPORTS*16-1:0] ADDR      = {PORT_1FFD, PORT_DFFD, PORT_7FFD},
  parameter logic [NPORTS*16-1:0] MASK      = {MASK_1FFD, MASK_DFFD, MASK_7FFD},
  parameter logic [NPORTS*DW-1:0] RESET_VAL = '0,
  parameter logic [NPORTS-1:0]    READABLE  = 3'b000,
  parameter logic [NPORTS-1:0]    SYNC_MASK = 3'b000,
  parameter logic [NPORTS-1:0]    LOCKABLE  = 3'b001,
  parameter int                   LOCK_PORT = 0,
  parameter int                   LOCK_BIT  = 5
) (
  input  logic                 clk28,
  input  logic                 rst_n,
  cpu_bus.slave                bus,
  input  logic                 clkcpu_ck,
  input  logic [NPORTS-1:0]    en,
  input  logic                 unlock,
  output logic [NPORTS*DW-1:0] q,
  output logic [NPORTS-1:0]    wr_stb,
  output logic                 locked,
  output logic [7:0]           d_out,
  output logic                 d_out_active
);

  if (NPORTS < 1 || NPORTS > 8 || DW < 1 || DW > 8 ||
      LOCK_PORT >= NPORTS || LOCK_BIT >= DW) begin : g_bad_params
    $error("ports_regbank: illegal parameter combination");
  end

  prb_state_e        state_q, state_d;
  logic [NPORTS-1:0] cs_s;
  logic [NPORTS-1:0] rd_hit_s;
  logic              wr_cyc_s;
  logic              sync_hit_s;
  logic              commit_s;
  logic [7:0]        ch_rdata [NPORTS];
  logic [7:0]        rd_data_s;
  logic [7:0]        d_out_q;
  logic              d_out_active_q;

  always_comb begin
    cs_s = '0;
    for (int i = 0; i < NPORTS; i++) begin
      cs_s[i] = en[i] & bus.ioreq &
                ((bus.a & MASK[i*16 +: 16]) == (ADDR[i*16 +: 16] & MASK[i*16 +: 16]));
    end
  end

  assign wr_cyc_s   = bus.wr & bus.ioreq;
  assign sync_hit_s = |(cs_s & SYNC_MASK);
  assign locked     = q[LOCK_PORT*DW + LOCK_BIT];

  always_comb begin
    state_d  = state_q;
    commit_s = 1'b0;
    case (state_q)
      PRB_IDLE: begin
        if (bus.wr && (|cs_s)) begin
          if (sync_hit_s) begin
            state_d = PRB_WAIT_CK;
          end else begin
            commit_s = 1'b1;
            state_d  = PRB_DONE;
          end
        end else begin
          state_d = PRB_IDLE;
        end
      end
      PRB_WAIT_CK: begin
        // An aborted bus cycle must not leave a pending commit behind.
        if (!wr_cyc_s) begin
          state_d = PRB_IDLE;
        end else if (clkcpu_ck) begin
          commit_s = 1'b1;
          state_d  = PRB_DONE;
        end else begin
          state_d = PRB_WAIT_CK;
        end
      end
      PRB_DONE: begin
        if (!wr_cyc_s) begin
          state_d = PRB_IDLE;
        end else begin
          state_d = PRB_DONE;
        end
      end
      default: state_d = PRB_IDLE;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_ch
    ports_regbank_ch #(
      .DW        (DW),
      .RESET_VAL (RESET_VAL[g*DW +: DW]),
      .LOCKABLE  (LOCKABLE[g])
    ) u_ch (
      .clk_i    (clk28),
      .rst_ni   (rst_n),
      .cs_i     (cs_s[g]),
      .commit_i (commit_s),
      .locked_i (locked),
      .unlock_i (unlock),
      .d_i      (bus.d[DW-1:0]),
      .q_o      (q[g*DW +: DW]),
      .wr_stb_o (wr_stb[g]),
      .rdata_o  (ch_rdata[g])
    );
  end

  // Walk from the top index down so the lowest matching readable channel wins.
  always_comb begin
    rd_hit_s  = cs_s & READABLE;
    rd_data_s = 8'hFF;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (rd_hit_s[i]) begin
        rd_data_s = ch_rdata[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      d_out_q        <= 8'hFF;
      d_out_active_q <= 1'b0;
    end else begin
      d_out_q        <= rd_data_s;
      d_out_active_q <= bus.ioreq & bus.rd & (|rd_hit_s);
    end
  end

  assign d_out        = d_out_q;
  assign d_out_active = d_out_active_q;

endmodule

// File: tb/tb_ports_regbank.sv
// Directed self-checking bench for ports_regbank: commit-once, lock, sync wait, enable,
// readback and asynchronous reset during a pending synchronised write.
module tb_ports_regbank;

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic        clkcpu_ck;
  logic [2:0]  en;
  logic        unlock;
  logic [23:0] q;
  logic [2:0]  wr_stb;
  logic        locked;
  logic [7:0]  d_out;
  logic        d_out_active;

  int n_chk  = 0;
  int n_pass = 0;
  int stb_cnt [3];

  cpu_bus bus_if ();

  ports_regbank #(
    .READABLE  (3'b011),
    .SYNC_MASK (3'b100)
  ) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .clkcpu_ck    (clkcpu_ck),
    .en           (en),
    .unlock       (unlock),
    .q            (q),
    .wr_stb       (wr_stb),
    .locked       (locked),
    .d_out        (d_out),
    .d_out_active (d_out_active)
  );

  always #18 clk28 = ~clk28;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk28);
    #1;
    for (int i = 0; i < 3; i++) stb_cnt[i] = stb_cnt[i] + int'(wr_stb[i]);
  endtask

  task automatic bus_idle();
    bus_if.ioreq = 1'b0;
    bus_if.rd    = 1'b0;
    bus_if.wr    = 1'b0;
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    for (int i = 0; i < 3; i++) stb_cnt[i] = 0;
    bus_if.a     = addr;
    bus_if.d     = data;
    bus_if.ioreq = 1'b1;
    bus_if.wr    = 1'b1;
    for (int k = 0; k < hold; k++) tick();
    bus_idle();
    tick();
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    clkcpu_ck = 1'b0;
    en        = 3'b111;
    unlock    = 1'b0;
    bus_if.a  = 16'h0000;
    bus_if.d  = 8'h00;
    bus_idle();
    for (int i = 0; i < 3; i++) stb_cnt[i] = 0;
    tick();
    tick();

    chk("rst_q", q, 24'h000000);
    chk("rst_stb", wr_stb, 3'b000);
    chk("rst_dout", d_out, 8'hFF);
    chk("rst_act", d_out_active, 1'b0);
    chk("rst_lock", locked, 1'b0);
    rst_n = 1'b1;
    tick();

    // Long write: exactly one commit
    io_write(16'h7FFD, 8'h17, 6);
    chk("t1_q", q, 24'h000017);
    chk("t1_stb0", stb_cnt[0], 1);
    chk("t1_stb12", stb_cnt[1] + stb_cnt[2], 0);

    // Lock set via partially-decoded alias
    io_write(16'h3FFD, 8'h20, 3);
    chk("t2_q0_set", q[7:0], 8'h20);
    chk("t2_locked", locked, 1'b1);
    io_write(16'h7FFD, 8'h07, 3);
    chk("t2_q0_blk", q[7:0], 8'h20);
    chk("t2_stb_blk", stb_cnt[0], 0);
    unlock = 1'b1;
    io_write(16'h7FFD, 8'h07, 3);
    unlock = 1'b0;
    chk("t2_q0_unl", q[7:0], 8'h07);
    chk("t2_unlocked", locked, 1'b0);
    chk("t2_stb_unl", stb_cnt[0], 1);

    // Disabled channel ignores the bus, enabled one takes it
    en = 3'b101;
    io_write(16'hDFFD, 8'h1F, 3);
    chk("t4_q1_dis", q[15:8], 8'h00);
    chk("t4_stb_dis", stb_cnt[1], 0);
    en = 3'b111;
    io_write(16'hDFFD, 8'h1A, 3);
    chk("t4_q1_en", q[15:8], 8'h1A);
    chk("t4_stb_en", stb_cnt[1], 1);

    // Synchronised write: 1FFD also aliases channel 0, both wait for clkcpu_ck
    bus_if.a = 16'h1FFD; bus_if.d = 8'h05; bus_if.ioreq = 1'b1; bus_if.wr = 1'b1;
    tick(); tick(); tick();
    chk("t3_q2_wait", q[23:16], 8'h00);
    chk("t3_q0_wait", q[7:0], 8'h07);
    chk("t3_stb_wait", wr_stb, 3'b000);
    clkcpu_ck = 1'b1;
    tick();
    clkcpu_ck = 1'b0;
    chk("t3_q2_commit", q[23:16], 8'h05);
    chk("t3_q0_commit", q[7:0], 8'h05);
    chk("t3_stb_commit", wr_stb, 3'b101);
    tick();
    chk("t3_stb_once", wr_stb, 3'b000);
    bus_idle();
    tick();
    // Aborted synchronised write
    bus_if.a = 16'h1FFD; bus_if.d = 8'h0A; bus_if.ioreq = 1'b1; bus_if.wr = 1'b1;
    tick(); tick();
    bus_idle();
    tick();
    clkcpu_ck = 1'b1;
    tick();
    clkcpu_ck = 1'b0;
    tick();
    chk("t3_q2_abort", q[23:16], 8'h05);
    chk("t3_q0_abort", q[7:0], 8'h05);

    // Readback
    io_write(16'h7FFD, 8'h12, 3);
    bus_if.a = 16'h7FFD; bus_if.ioreq = 1'b1; bus_if.rd = 1'b1;
    #1;
    chk("t5_act_lat", d_out_active, 1'b0);
    tick();
    chk("t5_act_7ffd", d_out_active, 1'b1);
    chk("t5_dout_7ffd", d_out, 8'h12);
    bus_if.a = 16'hDFFD;
    tick();
    chk("t5_dout_dffd", d_out, 8'h1A);
    en = 3'b110;
    bus_if.a = 16'h1FFD;
    tick();
    chk("t5_act_1ffd", d_out_active, 1'b0);
    chk("t5_dout_1ffd", d_out, 8'hFF);
    en = 3'b111;
    bus_if.a = 16'h7FFD; bus_if.rd = 1'b0;
    tick();
    chk("t5_act_nord", d_out_active, 1'b0);
    bus_idle();
    tick();

    // Reset while waiting for clkcpu_ck
    bus_if.a = 16'h1FFD; bus_if.d = 8'h33; bus_if.ioreq = 1'b1; bus_if.wr = 1'b1;
    tick(); tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_q", q, 24'h000000);
    chk("t6_stb", wr_stb, 3'b000);
    chk("t6_dout", d_out, 8'hFF);
    chk("t6_act", d_out_active, 1'b0);
    clkcpu_ck = 1'b1;
    tick();
    clkcpu_ck = 1'b0;
    bus_idle();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_q_after", q, 24'h000000);
    io_write(16'h7FFD, 8'h03, 3);
    chk("t6_q0_new", q[7:0], 8'h03);
    chk("t6_stb_new", stb_cnt[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
